// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES job sequencer.
package aes_pkg;

  localparam int WORDSIZE    = 64;
  localparam int KEY_WORDS   = 4;
  localparam int BLOCK_WORDS = 2;
  localparam int NBLK_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of stream words a job of nblocks blocks moves in each direction.
  function automatic logic [NBLK_W:0] job_words(input logic [NBLK_W-1:0] nblocks);
    return (NBLK_W+1)'(nblocks) * (NBLK_W+1)'(BLOCK_WORDS);
  endfunction

endpackage

// File: rtl/aes_job_ctrl.sv
// Job-level sequencer in front of the AES-256 stream engine. One command
// starts a job (optional key load plus N blocks); the key, block and result
// streams are gated combinationally and counted so the job can finish once
// the last result word has been accepted by the sink.
module aes_job_ctrl
  import aes_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_rekey_i,
  input  logic [NBLK_W-1:0]   cmd_nblocks_i,

  input  logic [WORDSIZE-1:0] src_key_data_i,
  input  logic                src_key_valid_i,
  output logic                src_key_ready_o,

  input  logic [WORDSIZE-1:0] src_blk_data_i,
  input  logic                src_blk_valid_i,
  output logic                src_blk_ready_o,

  output logic [WORDSIZE-1:0] eng_key_data_o,
  output logic                eng_key_valid_o,
  input  logic                eng_key_ready_i,

  output logic [WORDSIZE-1:0] eng_blk_data_o,
  output logic                eng_blk_valid_o,
  input  logic                eng_blk_ready_i,

  input  logic [WORDSIZE-1:0] eng_res_data_i,
  input  logic                eng_res_valid_i,
  output logic                eng_res_ready_o,

  output logic [WORDSIZE-1:0] dst_data_o,
  output logic                dst_valid_o,
  input  logic                dst_ready_i,

  output logic                busy_o,
  output logic                done_o,
  output logic [NBLK_W-1:0]   res_blocks_o
);

  localparam int KCNT_W = (KEY_WORDS   > 1) ? $clog2(KEY_WORDS)   : 1;
  localparam int BCNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int WCNT_W = NBLK_W + 1;

  state_t              state_q;
  state_t              state_d;
  logic [NBLK_W-1:0]   nblocks_q;
  logic [KCNT_W-1:0]   key_cnt_q;
  logic [WCNT_W-1:0]   in_cnt_q;
  logic [WCNT_W-1:0]   out_cnt_q;
  logic [BCNT_W-1:0]   blk_word_cnt_q;
  logic [NBLK_W-1:0]   res_blocks_q;
  logic [WCNT_W-1:0]   target;

  logic                key_phase;
  logic                blk_phase;
  logic                res_en;
  logic                cmd_hs;
  logic                key_hs;
  logic                blk_hs;
  logic                res_hs;
  logic                key_last;
  logic                out_last;
  logic                blk_word_last;

  // Phase qualifiers: block input closes once all words of the job are in,
  // results flow for the whole RUN state.
  assign target    = job_words(nblocks_q);
  assign key_phase = (state_q == KEY);
  assign blk_phase = (state_q == RUN) && (in_cnt_q != target);
  assign res_en    = (state_q == RUN);

  // Status outputs decode straight from the state register.
  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q == KEY) || (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign res_blocks_o = res_blocks_q;

  // Combinational stream gating; no data is registered on any path.
  assign eng_key_data_o  = src_key_data_i;
  assign eng_key_valid_o = src_key_valid_i & key_phase;
  assign src_key_ready_o = eng_key_ready_i & key_phase;

  assign eng_blk_data_o  = src_blk_data_i;
  assign eng_blk_valid_o = src_blk_valid_i & blk_phase;
  assign src_blk_ready_o = eng_blk_ready_i & blk_phase;

  assign dst_data_o      = eng_res_data_i;
  assign dst_valid_o     = eng_res_valid_i & res_en;
  assign eng_res_ready_o = dst_ready_i & res_en;

  // Transfer strobes and the "last word" conditions that drive the FSM.
  assign cmd_hs        = cmd_valid_i & cmd_ready_o;
  assign key_hs        = eng_key_valid_o & eng_key_ready_i;
  assign blk_hs        = eng_blk_valid_o & eng_blk_ready_i;
  assign res_hs        = dst_valid_o & dst_ready_i;
  assign key_last      = key_hs && (key_cnt_q == KCNT_W'(KEY_WORDS - 1));
  assign out_last      = res_hs && ((out_cnt_q + WCNT_W'(1)) == target);
  assign blk_word_last = (blk_word_cnt_q == BCNT_W'(BLOCK_WORDS - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the rekey/zero-block routing is decided from the
  // command fields at the handshake so no rekey flag needs to be kept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_rekey_i) begin
            state_d = KEY;
          end else if (cmd_nblocks_i != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      KEY: begin
        if (key_last) begin
          state_d = (nblocks_q != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the block count of the accepted command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nblocks_q <= '0;
    end else if (cmd_hs) begin
      nblocks_q <= cmd_nblocks_i;
    end
  end

  // Key word counter, wraps after the last word of a key.
  always_ff @(posedge clk_i) begin
    if (rst_i || cmd_hs) begin
      key_cnt_q <= '0;
    end else if (key_hs) begin
      key_cnt_q <= key_last ? '0 : key_cnt_q + KCNT_W'(1);
    end
  end

  // Plaintext words handed to the engine in this job.
  always_ff @(posedge clk_i) begin
    if (rst_i || cmd_hs) begin
      in_cnt_q <= '0;
    end else if (blk_hs) begin
      in_cnt_q <= in_cnt_q + WCNT_W'(1);
    end
  end

  // Result words handed to the sink in this job.
  always_ff @(posedge clk_i) begin
    if (rst_i || cmd_hs) begin
      out_cnt_q <= '0;
    end else if (res_hs) begin
      out_cnt_q <= out_cnt_q + WCNT_W'(1);
    end
  end

  // Completed-block count: one more every BLOCK_WORDS result words.
  always_ff @(posedge clk_i) begin
    if (rst_i || cmd_hs) begin
      blk_word_cnt_q <= '0;
      res_blocks_q   <= '0;
    end else if (res_hs) begin
      if (blk_word_last) begin
        blk_word_cnt_q <= '0;
        res_blocks_q   <= res_blocks_q + NBLK_W'(1);
      end else begin
        blk_word_cnt_q <= blk_word_cnt_q + BCNT_W'(1);
      end
    end
  end

endmodule
